aes_axil_master: RTL and testbench

- AXI4-Lite master that drives the AES encryption AXI slave wrapper from a simple 128-bit valid/ready stream.
- Per job it writes key words to 0x10–0x1C, then plaintext words to 0x00–0x0C; the last plaintext write starts encryption.
- It then waits a fixed number of cycles, reads ciphertext from 0x20–0x2C and presents the 128-bit result downstream.
- Sits between the Nios V-side job queue and the AES wrapper; removes per-word CPU traffic.

---
 rtl/aes_axil_master.sv | 227 ++++++++++++++++++++++
 tb/tb_aes_axil_master.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axil_master.sv
// AXI4-Lite master that feeds one 128-bit key/plaintext job at a time into the
// AES slave wrapper. It writes the key and plaintext words, waits a fixed number
// of cycles for the core, then reads back the ciphertext and presents it downstream.
module aes_axil_master #(
  parameter int unsigned        ADDR_W   = 6,
  parameter int unsigned        ENC_WAIT = 16,
  parameter logic [ADDR_W-1:0]  KEY_BASE = 'h10,
  parameter logic [ADDR_W-1:0]  PT_BASE  = 'h00,
  parameter logic [ADDR_W-1:0]  CT_BASE  = 'h20
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [127:0]      s_key,
  input  logic [127:0]      s_pt,
  input  logic              s_key_same,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [127:0]      m_ct,
  output logic              m_err,
  output logic              busy,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [2:0]        M_AXI_AWPROT,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  output logic [2:0]        M_AXI_ARPROT,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_BRESP, S_WAIT, S_RADDR, S_RDATA, S_OUT
  } state_t;

  localparam int unsigned      CNT_W    = (ENC_WAIT > 1) ? $clog2(ENC_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENC_WAIT - 1);

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [127:0]        key_q, key_d;
  logic [127:0]        pt_q, pt_d;
  logic [127:0]        ct_q, ct_d;
  logic                err_q, err_d;
  logic                key_loaded_q, key_loaded_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s_ready_q, s_ready_d;

  // Words 0-3 go to the key registers, words 4-7 to the plaintext registers.
  function automatic logic [ADDR_W-1:0] wr_addr(input logic [2:0] i);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'({i[1:0], 2'b00});
    return i[2] ? (PT_BASE + off) : (KEY_BASE + off);
  endfunction

  function automatic logic [31:0] wr_word(input logic [255:0] kp, input logic [2:0] i);
    return kp[{3'd7 - i, 5'd0} +: 32];
  endfunction

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [1:0] i);
    return CT_BASE + ADDR_W'({i, 2'b00});
  endfunction

  // Next-state and datapath decisions; every register holds unless a state updates it.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    key_d        = key_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    err_d        = err_q;
    key_loaded_d = key_loaded_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    araddr_d     = araddr_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid && s_ready_q) begin
          key_d     = s_key;
          pt_d      = s_pt;
          idx_d     = (s_key_same && key_loaded_q) ? 3'd4 : 3'd0;
          err_d     = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = wr_addr(idx_d);
          wdata_d   = wr_word({s_key, s_pt}, idx_d);
          state_d   = S_WR;
        end
      end
      S_WR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_BRESP;
      end
      S_BRESP: begin
        if (M_AXI_BVALID) begin
          err_d = err_q | (M_AXI_BRESP != 2'b00);
          if (idx_q == 3'd7) begin
            key_loaded_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_WAIT;
          end else begin
            idx_d     = idx_q + 3'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = wr_addr(idx_d);
            wdata_d   = wr_word({key_q, pt_q}, idx_d);
            state_d   = S_WR;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          idx_d     = 3'd0;
          arvalid_d = 1'b1;
          araddr_d  = rd_addr(2'd0);
          state_d   = S_RADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          ct_d[{2'd3 - idx_q[1:0], 5'd0} +: 32] = M_AXI_RDATA;
          err_d = err_q | (M_AXI_RRESP != 2'b00);
          if (idx_q == 3'd3) begin
            state_d = S_OUT;
          end else begin
            idx_d     = idx_q + 3'd1;
            arvalid_d = 1'b1;
            araddr_d  = rd_addr(idx_d[1:0]);
            state_d   = S_RADDR;
          end
        end
      end
      S_OUT: begin
        if (m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so that s_ready only rises the cycle after the result handshake.
    s_ready_d = (state_d == S_IDLE);
  end

  // State register; reset aborts any transfer and forgets the loaded key.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      err_q        <= 1'b0;
      key_loaded_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      araddr_q     <= '0;
      cnt_q        <= '0;
      s_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      err_q        <= err_d;
      key_loaded_q <= key_loaded_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      araddr_q     <= araddr_d;
      cnt_q        <= cnt_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign m_valid       = (state_q == S_OUT);
  assign m_ct          = ct_q;
  assign m_err         = err_q;
  assign busy          = (state_q != S_IDLE);
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'b1111;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_BRESP);
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == S_RDATA);

endmodule

// File: tb/tb_aes_axil_master.sv
// Directed bench for aes_axil_master: a behavioural AXI4-Lite slave stub records
// every write/read and returns preset ciphertext words; each test task checks
// the recorded traffic and the downstream result against hand-written values.
module tb_aes_axil_master;
  localparam int ENC_WAIT = 16;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         s_valid, s_ready, s_key_same;
  logic [127:0] s_key, s_pt;
  logic         m_valid, m_ready, m_err, busy;
  logic [127:0] m_ct;
  logic [5:0]   M_AXI_AWADDR, M_AXI_ARADDR;
  logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic [31:0]  M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]   M_AXI_WSTRB;
  logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
  logic         M_AXI_BVALID, M_AXI_BREADY;
  logic         M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

  aes_axil_master #(.ENC_WAIT(ENC_WAIT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_pt(s_pt), .s_key_same(s_key_same),
    .m_valid(m_valid), .m_ready(m_ready), .m_ct(m_ct), .m_err(m_err), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Slave configuration, written only by the main sequence.
  int          max_dly   = 0;
  bit          stress_late = 0;
  bit          err_en    = 0;
  logic [5:0]  err_addr  = 6'h00;
  bit          slow_r    = 0;
  logic [31:0] ct_mem [4];

  // Slave observations; each written by exactly one slave process.
  logic [5:0]  wr_a [$];
  logic [31:0] wr_d [$];
  logic [5:0]  rd_a [$];
  int wr_proto = 0;
  int rd_proto = 0;
  int b_cnt = 0;
  int last_b_cyc = 0;
  int gap_obs = -1;

  function automatic int pick_dly();
    return int'($urandom_range(max_dly, 0));
  endfunction

  // Write-side slave: AW and W accepted independently after random delays, then B.
  initial begin : slave_wr
    int aw_dly, w_dly, b_dly, n;
    bit aw_got, w_got, aw_pend, w_pend, in_b;
    logic [5:0] a;
    logic [31:0] d;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; in_b = 0; n = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; a = 0; d = 0;
    forever begin
      @(negedge ACLK);
      M_AXI_AWREADY = 0;
      M_AXI_WREADY  = 0;
      if (ARESET) begin
        M_AXI_BVALID = 0; aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; in_b = 0;
        aw_dly = pick_dly(); w_dly = pick_dly();
      end else if (in_b) begin
        if (M_AXI_AWVALID || M_AXI_WVALID) wr_proto++;
        if (b_dly > 0) begin
          b_dly--;
        end else begin
          M_AXI_BVALID = 1;
          M_AXI_BRESP  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
          if (M_AXI_BREADY) begin
            last_b_cyc = cyc; b_cnt++; in_b = 0; aw_got = 0; w_got = 0; n++;
            w_dly = pick_dly();
            aw_dly = (stress_late && n[0]) ? w_dly + 2 : pick_dly();
          end
        end
      end else begin
        M_AXI_BVALID = 0;
        if (!aw_got) begin
          if (aw_pend && (!M_AXI_AWVALID || M_AXI_AWADDR !== a)) wr_proto++;
          aw_pend = 0;
          if (M_AXI_AWVALID) begin
            a = M_AXI_AWADDR;
            if (aw_dly == 0) begin M_AXI_AWREADY = 1; aw_got = 1; end
            else begin aw_dly--; aw_pend = 1; end
          end
        end
        if (!w_got) begin
          if (w_pend && (!M_AXI_WVALID || M_AXI_WDATA !== d)) wr_proto++;
          w_pend = 0;
          if (M_AXI_WVALID) begin
            d = M_AXI_WDATA;
            if (w_dly == 0) begin M_AXI_WREADY = 1; w_got = 1; end
            else begin w_dly--; w_pend = 1; end
          end
        end
        if (aw_got && w_got) begin
          wr_a.push_back(a); wr_d.push_back(d);
          in_b = 1; b_dly = pick_dly();
        end
      end
    end
  end

  // Read-side slave: AR accepted after a random delay, then R with the preset word.
  initial begin : slave_rd
    int ar_dly, r_dly, b_seen;
    bit in_r, ar_pend;
    logic [5:0] ra;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    ar_dly = 0; r_dly = 0; b_seen = 0; in_r = 0; ar_pend = 0; ra = 0;
    forever begin
      @(negedge ACLK);
      M_AXI_ARREADY = 0;
      if (ARESET) begin
        M_AXI_RVALID = 0; in_r = 0; ar_pend = 0; ar_dly = pick_dly();
      end else if (in_r) begin
        if (M_AXI_ARVALID) rd_proto++;
        if (r_dly > 0) begin
          r_dly--;
        end else begin
          M_AXI_RVALID = 1;
          M_AXI_RDATA  = ct_mem[ra[3:2]];
          M_AXI_RRESP  = 2'b00;
          if (M_AXI_RREADY) begin in_r = 0; ar_dly = pick_dly(); end
        end
      end else begin
        M_AXI_RVALID = 0;
        if (ar_pend && (!M_AXI_ARVALID || M_AXI_ARADDR !== ra)) rd_proto++;
        ar_pend = 0;
        if (M_AXI_ARVALID) begin
          if (b_cnt != b_seen) begin gap_obs = cyc - last_b_cyc; b_seen = b_cnt; end
          ra = M_AXI_ARADDR;
          if (ar_dly == 0) begin
            M_AXI_ARREADY = 1; rd_a.push_back(ra); in_r = 1;
            r_dly = slow_r ? 30 : pick_dly();
          end else begin
            ar_dly--; ar_pend = 1;
          end
        end
      end
    end
  end

  // Offers one job and waits for its result; starts and ends on a falling edge.
  task automatic run_job(input logic [127:0] key, input logic [127:0] pt, input logic same,
                         input bit hold_ready, output logic [127:0] ct, output logic err,
                         output bit done);
    int n;
    done = 0; ct = '0; err = 1'b0;
    s_key = key; s_pt = pt; s_key_same = same; s_valid = 1;
    n = 0;
    while (!s_ready && n < 500) begin @(negedge ACLK); n++; end
    if (!s_ready) begin s_valid = 0; return; end
    @(negedge ACLK);
    s_valid = 0;
    n = 0;
    while (!m_valid && n < 3000) begin @(negedge ACLK); n++; end
    if (!m_valid) return;
    ct = m_ct; err = m_err; done = 1;
    if (!hold_ready) begin
      m_ready = 1;
      @(negedge ACLK);
      m_ready = 0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({s_ready, m_valid, m_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: s_ready/m_valid/m_err/busy=%b required 0000", {s_ready, m_valid, m_err, busy});
    end
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b00000) begin
      errors++; $display("FAIL reset_axi_handshakes: got %b required 00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
    end
    checks++;
    if (m_ct !== 128'h0 || M_AXI_AWADDR !== 6'h0 || M_AXI_WDATA !== 32'h0 || M_AXI_ARADDR !== 6'h0) begin
      errors++; $display("FAIL reset_data: m_ct=%h awaddr=%h wdata=%h araddr=%h required all 0",
        m_ct, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR);
    end
    checks++;
    if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000 || M_AXI_WSTRB !== 4'b1111) begin
      errors++; $display("FAIL constants: awprot=%b arprot=%b wstrb=%b required 000/000/1111",
        M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB);
    end
    ARESET = 0;
    @(negedge ACLK);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: s_ready=%b busy=%b required 1 0", s_ready, busy);
    end
    $display("test_reset: done");
  endtask

  task automatic test_fips();
    logic [5:0]  ea [8];
    logic [31:0] ed [8];
    logic [127:0] ct; logic err; bit done; int wb, rb;
    ea = '{6'h10, 6'h14, 6'h18, 6'h1C, 6'h00, 6'h04, 6'h08, 6'h0C};
    ed = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
           32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    ct_mem = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    wb = wr_a.size(); rb = rd_a.size();
    run_job(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
            1'b0, 1'b0, ct, err, done);
    checks++;
    if (!done) begin errors++; $display("FAIL fips_done: job did not complete within budget"); end
    checks++;
    if (wr_a.size() - wb !== 8) begin
      errors++; $display("FAIL fips_wr_count: got %0d required 8", wr_a.size() - wb);
    end
    for (int i = 0; i < 8; i++) begin
      if (wb + i < wr_a.size()) begin
        checks++;
        if (wr_a[wb + i] !== ea[i] || wr_d[wb + i] !== ed[i]) begin
          errors++; $display("FAIL fips_wr%0d: got %h=%h required %h=%h", i, wr_a[wb + i], wr_d[wb + i], ea[i], ed[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (rb + i < rd_a.size()) begin
        checks++;
        if (rd_a[rb + i] !== 6'h20 + 6'(4 * i)) begin
          errors++; $display("FAIL fips_rd%0d: got %h required %h", i, rd_a[rb + i], 6'h20 + 6'(4 * i));
        end
      end
    end
    checks++;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || err !== 1'b0) begin
      errors++; $display("FAIL fips_result: ct=%h err=%b required 69c4e0d86a7b0430d8cdb78070b4c55a 0", ct, err);
    end
    checks++;
    if (gap_obs !== ENC_WAIT + 1) begin
      errors++; $display("FAIL fips_enc_wait: B-to-AR cycles=%0d required %0d", gap_obs, ENC_WAIT + 1);
    end
    $display("test_fips: ct=%h err=%b writes=%0d", ct, err, wr_a.size() - wb);
  endtask

  task automatic test_key_reuse();
    logic [127:0] ct; logic err; bit done; int wb;
    ct_mem = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h0f1e2d3c};
    wb = wr_a.size();
    run_job(128'hffffffffffffffffffffffffffffffff, 128'h0, 1'b1, 1'b0, ct, err, done);
    checks++;
    if (!done || wr_a.size() - wb !== 4) begin
      errors++; $display("FAIL reuse_wr_count: done=%b writes=%0d required 1 4", done, wr_a.size() - wb);
    end
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wr_a.size()) begin
        checks++;
        if (wr_a[wb + i] !== 6'(4 * i) || wr_d[wb + i] !== 32'h0) begin
          errors++; $display("FAIL reuse_wr%0d: got %h=%h required %h=00000000", i, wr_a[wb + i], wr_d[wb + i], 6'(4 * i));
        end
      end
    end
    checks++;
    if (ct !== 128'hdeadbeef0123456789abcdef0f1e2d3c || err !== 1'b0) begin
      errors++; $display("FAIL reuse_result: ct=%h err=%b required deadbeef0123456789abcdef0f1e2d3c 0", ct, err);
    end
    $display("test_key_reuse: ct=%h writes=%0d", ct, wr_a.size() - wb);
  endtask

  task automatic test_stress();
    logic [31:0] ed [8];
    logic [127:0] ct; logic err; bit done; int wb, rb;
    ed = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
           32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
    ct_mem = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
    max_dly = 5; stress_late = 1;
    for (int j = 0; j < 2; j++) begin
      wb = wr_a.size(); rb = rd_a.size();
      run_job(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              1'b0, 1'b0, ct, err, done);
      checks++;
      if (!done || wr_a.size() - wb !== 8 || rd_a.size() - rb !== 4) begin
        errors++; $display("FAIL stress%0d_counts: done=%b writes=%0d reads=%0d required 1 8 4",
          j, done, wr_a.size() - wb, rd_a.size() - rb);
      end
      for (int i = 0; i < 8; i++) begin
        if (wb + i < wr_a.size()) begin
          checks++;
          if (wr_a[wb + i] !== (i < 4 ? 6'h10 + 6'(4 * i) : 6'(4 * (i - 4))) || wr_d[wb + i] !== ed[i]) begin
            errors++; $display("FAIL stress%0d_wr%0d: got %h=%h required data %h", j, i, wr_a[wb + i], wr_d[wb + i], ed[i]);
          end
        end
      end
      checks++;
      if (ct !== 128'h3925841d02dc09fbdc118597196a0b32 || err !== 1'b0) begin
        errors++; $display("FAIL stress%0d_result: ct=%h err=%b required 3925841d02dc09fbdc118597196a0b32 0", j, ct, err);
      end
      checks++;
      if (gap_obs !== ENC_WAIT + 1) begin
        errors++; $display("FAIL stress%0d_enc_wait: B-to-AR cycles=%0d required %0d", j, gap_obs, ENC_WAIT + 1);
      end
      $display("test_stress[%0d]: ct=%h gap=%0d", j, ct, gap_obs);
    end
    checks++;
    if (wr_proto !== 0 || rd_proto !== 0) begin
      errors++; $display("FAIL valid_hold: write-side violations=%0d read-side violations=%0d required 0 0", wr_proto, rd_proto);
    end
    max_dly = 0; stress_late = 0;
  endtask

  task automatic test_error();
    logic [127:0] ct; logic err; bit done; int wb;
    ct_mem = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    max_dly = 1; err_en = 1; err_addr = 6'h08;
    wb = wr_a.size();
    run_job(128'h0, 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c, 1'b1, 1'b0, ct, err, done);
    checks++;
    if (!done || err !== 1'b1 || wr_a.size() - wb !== 4) begin
      errors++; $display("FAIL error_job: done=%b m_err=%b writes=%0d required 1 1 4", done, err, wr_a.size() - wb);
    end
    checks++;
    if (ct !== 128'h11111111222222223333333344444444) begin
      errors++; $display("FAIL error_ct: got %h required 11111111222222223333333344444444", ct);
    end
    err_en = 0;
    run_job(128'h0, 128'h1, 1'b1, 1'b0, ct, err, done);
    checks++;
    if (!done || err !== 1'b0) begin
      errors++; $display("FAIL clean_after_error: done=%b m_err=%b required 1 0", done, err);
    end
    max_dly = 0;
    $display("test_error: clean job m_err=%b", err);
  endtask

  task automatic test_backpressure();
    logic [127:0] ct; logic err; bit done; int wb;
    ct_mem = '{32'hcafef00d, 32'h00c0ffee, 32'h12345678, 32'h9abcdef0};
    run_job(128'h0, 128'h2, 1'b1, 1'b1, ct, err, done);
    checks++;
    if (!done || ct !== 128'hcafef00d00c0ffee123456789abcdef0) begin
      errors++; $display("FAIL bp_result: done=%b ct=%h required 1 cafef00d00c0ffee123456789abcdef0", done, ct);
    end
    wb = wr_a.size();
    s_key = 128'h5; s_pt = 128'h6; s_key_same = 0; s_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      checks++;
      if (m_valid !== 1'b1 || m_ct !== ct || m_err !== err || s_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: m_valid=%b m_ct=%h s_ready=%b required 1 %h 0", i, m_valid, m_ct, s_ready, ct);
      end
    end
    s_valid = 0;
    checks++;
    if (wr_a.size() !== wb) begin
      errors++; $display("FAIL bp_no_accept: writes during hold=%0d required 0", wr_a.size() - wb);
    end
    m_ready = 1;
    @(negedge ACLK);
    m_ready = 0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: m_valid=%b s_ready=%b busy=%b required 0 1 0", m_valid, s_ready, busy);
    end
    $display("test_backpressure: held 10 cycles ct=%h", ct);
  endtask

  task automatic test_reset_mid_read();
    logic [127:0] ct; logic err; bit done; int n, wb;
    ct_mem = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    slow_r = 1;
    s_key = 128'h000102030405060708090a0b0c0d0e0f; s_pt = 128'h7; s_key_same = 1; s_valid = 1;
    n = 0;
    while (!s_ready && n < 500) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    s_valid = 0;
    n = 0;
    while (!M_AXI_RREADY && n < 3000) begin @(negedge ACLK); n++; end
    checks++;
    if (M_AXI_RREADY !== 1'b1) begin
      errors++; $display("FAIL mid_read_reach: RREADY=%b required 1", M_AXI_RREADY);
    end
    #1 ARESET = 1;
    #1;
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_BREADY, m_valid, busy} !== 7'b0) begin
      errors++; $display("FAIL async_reset: aw/w/ar/rready/bready/m_valid/busy=%b required 0000000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_BREADY, m_valid, busy});
    end
    checks++;
    if (m_ct !== 128'h0 || m_err !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset_out: m_ct=%h m_err=%b s_ready=%b required 0 0 0", m_ct, m_err, s_ready);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    slow_r = 0;
    #1 ARESET = 0;
    wb = wr_a.size();
    run_job(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
            1'b1, 1'b0, ct, err, done);
    checks++;
    if (!done || wr_a.size() - wb !== 8) begin
      errors++; $display("FAIL key_rewrite_count: done=%b writes=%0d required 1 8", done, wr_a.size() - wb);
    end
    checks++;
    if (wb < wr_a.size() && (wr_a[wb] !== 6'h10 || wr_d[wb] !== 32'h00010203)) begin
      errors++; $display("FAIL key_rewrite_first: got %h=%h required 10=00010203", wr_a[wb], wr_d[wb]);
    end
    checks++;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || err !== 1'b0) begin
      errors++; $display("FAIL key_rewrite_result: ct=%h err=%b", ct, err);
    end
    $display("test_reset_mid_read: post-reset writes=%0d ct=%h", wr_a.size() - wb, ct);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    ARESET = 1; s_valid = 0; s_key = '0; s_pt = '0; s_key_same = 0; m_ready = 0;
    ct_mem = '{32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(negedge ACLK);
    test_reset();
    test_fips();
    test_key_reuse();
    test_stress();
    test_error();
    test_backpressure();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
